// File: rtl/rv_tx_arbiter_if.sv
// Requester-side and downstream-side handshake bundle for rv_tx_arbiter.
interface rv_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 64
);
  localparam int unsigned SW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic [SW-1:0]         out_src;
  logic [31:0]           xfer_count;

  // Environment side: drives requests and downstream ready.
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, xfer_count
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, xfer_count
  );
endinterface

// File: rtl/rv_tx_arbiter.sv
// Round-robin N:1 arbiter with a single registered output slot.
// Accepts in IDLE, presents in BUSY; one transfer per two cycles at best.
module rv_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 64
) (
  input logic            clk,
  input logic            reset,
  rv_tx_arbiter_if.slave bus
);
  localparam int unsigned SW = $clog2(NUM_REQ);

  typedef enum logic {StIdle, StBusy} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]    out_src_q, out_src_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [31:0]      xfer_count_q, xfer_count_d;
  logic [SW-1:0]    winner;
  logic             found;
  logic [NUM_REQ-1:0] req_ready;
  logic             out_valid;

  // First set req_valid bit searching upward from rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[SW'(idx)]) begin
        found  = 1'b1;
        winner = SW'(idx);
      end
    end
  end

  // Next-state logic and handshake outputs; reset masks both handshakes.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    out_src_d    = out_src_q;
    out_data_d   = out_data_q;
    xfer_count_d = xfer_count_q;
    req_ready    = '0;
    out_valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          req_ready  = NUM_REQ'(1) << winner;
          out_data_d = bus.req_data[winner*DW +: DW];
          out_src_d  = winner;
          rr_ptr_d   = (winner == SW'(NUM_REQ - 1)) ? '0 : winner + SW'(1);
          state_d    = StBusy;
        end
      end
      StBusy: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          xfer_count_d = xfer_count_q + 32'd1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      req_ready = '0;
      out_valid = 1'b0;
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      out_src_q    <= '0;
      out_data_q   <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      out_src_q    <= out_src_d;
      out_data_q   <= out_data_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data_q;
  assign bus.out_src    = out_src_q;
  assign bus.xfer_count = xfer_count_q;
endmodule

// File: tb/tb_rv_tx_arbiter.sv
// Directed and random checks of rv_tx_arbiter against a transaction-level model.
module tb_rv_tx_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_tx_arbiter_if #(.NUM_REQ(N), .DW(W)) bus ();

  rv_tx_arbiter #(.NUM_REQ(N), .DW(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] dat [N];

  // Model: slot occupancy, next-priority pointer, held payload, transfer count.
  bit          m_busy;
  int          m_ptr;
  logic [W-1:0] m_data;
  int          m_src;
  logic [31:0] m_count;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (p + k) % int'(N);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic rdy);
    int w;
    logic [N-1:0] exp_rdy;
    reset         = r;
    bus.req_valid = v;
    bus.out_ready = rdy;
    for (int k = 0; k < int'(N); k++) bus.req_data[k*W +: W] = dat[k];
    #2;
    w = pick(v, m_ptr);
    exp_rdy = '0;
    if (!r && !m_busy && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready",  W'(bus.req_ready),  W'(exp_rdy));
    chk("out_valid",  W'(bus.out_valid),  W'(m_busy && !r));
    chk("out_data",   bus.out_data,       m_data);
    chk("out_src",    W'(bus.out_src),    W'(m_src));
    chk("xfer_count", W'(bus.xfer_count), W'(m_count));
    @(posedge clk);
    #1;
    if (r) begin
      m_busy = 0; m_ptr = 0; m_src = 0; m_data = '0; m_count = '0;
    end else if (m_busy) begin
      if (rdy) begin
        m_count++;
        m_busy = 0;
      end
    end else if (w >= 0) begin
      m_busy = 1;
      m_data = dat[w];
      m_src  = w;
      m_ptr  = (w + 1) % int'(N);
    end
  endtask

  initial begin
    logic [31:0] c0;
    for (int k = 0; k < int'(N); k++) dat[k] = {32'hA5A5_0000 + 32'(k), 32'h0000_1000 + 32'(k)};
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    bus.req_data  = '0;
    m_busy = 0; m_ptr = 0; m_src = 0; m_data = '0; m_count = '0;
    @(posedge clk);
    #1;

    // Reset state.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);

    // Single request on requester 2.
    dat[2] = 64'hDEAD_BEEF_0000_0001;
    cycle(1'b0, 4'b0100, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);

    // Fresh reset so round-robin starts from requester 0.
    cycle(1'b1, 4'b0000, 1'b0);
    c0 = bus.xfer_count;
    for (int i = 0; i < 16; i++) cycle(1'b0, 4'b1111, 1'b1);
    chk("rr_count16", W'(bus.xfer_count - c0), W'(8));

    // Backpressure: grant requester 1, hold out_ready low 5 cycles.
    cycle(1'b0, 4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b1111, 1'b0);
    cycle(1'b0, 4'b1111, 1'b1);
    cycle(1'b0, 4'b1111, 1'b1);
    chk("bp_next_src", W'(bus.out_src), W'(2));
    cycle(1'b0, 4'b0000, 1'b1);

    // Wrap: make rr_ptr 3 by granting 2, then 0b0011 must pick 0, then 1.
    cycle(1'b0, 4'b0100, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0011, 1'b1);
    chk("wrap_src0", W'(bus.out_src), W'(0));
    cycle(1'b0, 4'b0011, 1'b1);
    cycle(1'b0, 4'b0011, 1'b1);
    chk("wrap_src1", W'(bus.out_src), W'(1));
    cycle(1'b0, 4'b0000, 1'b1);

    // Reset mid-transfer while holding requester 3.
    cycle(1'b0, 4'b1000, 1'b0);
    cycle(1'b0, 4'b1000, 1'b0);
    cycle(1'b1, 4'b1000, 1'b1);
    cycle(1'b0, 4'b1010, 1'b0);
    chk("post_rst_src", W'(bus.out_src), W'(1));
    cycle(1'b0, 4'b0000, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic rdy;
      logic [N-1:0] v;
      for (int k = 0; k < int'(N); k++) dat[k] = {$urandom, $urandom};
      r   = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      v   = N'($urandom_range(0, 15));
      cycle(r, v, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv_tx_arbiter.md
RV_TX_ARBITER -- requirements
Module: rv_tx_arbiter

Interface
- REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters; legal values 2..8.
- REQ-002 SHALL have parameter DW, default 64: data width in bits.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
- REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester valid.
- REQ-006 SHALL have port req_data, input, NUM_REQ*DW bits: requester i data in bits [i*DW +: DW].
- REQ-007 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept.
- REQ-008 SHALL have port out_valid, output, 1 bit: downstream valid.
- REQ-009 SHALL have port out_ready, input, 1 bit: downstream ready.
- REQ-010 SHALL have port out_data, output, DW bits: registered payload.
- REQ-011 SHALL have port out_src, output, $clog2(NUM_REQ) bits: index of the requester that owns out_data.
- REQ-012 SHALL have port xfer_count, output, 32 bits: count of completed downstream handshakes.

Function
- REQ-013 SHALL be an FSM with two states: IDLE and BUSY.
- REQ-014 SHALL, in IDLE with req_valid nonzero, select winner w as the first set req_valid bit found by searching upward from rr_ptr, wrapping modulo NUM_REQ.
- REQ-015 SHALL, in that same IDLE cycle, drive req_ready combinationally as one-hot on w.
  - At the clock edge: capture req_data[w] into out_data and w into out_src.
  - Set rr_ptr to (w+1) mod NUM_REQ.
  - Go to BUSY.
- REQ-016 SHALL, in IDLE with req_valid all zero, drive req_ready to 0 and leave out_data, out_src and rr_ptr unchanged.
- REQ-017 SHALL drive out_valid as 1 exactly when state is BUSY; latency from accept to out_valid is 1 cycle.
- REQ-018 SHALL, in BUSY, drive req_ready all zero and hold out_data and out_src stable until the handshake.
- REQ-019 SHALL, in BUSY with out_ready=1:
  - complete the transfer;
  - increment xfer_count by 1, wrapping from 0xFFFFFFFF to 0;
  - return to IDLE, so the next accept occurs at the earliest in the following cycle.
- REQ-020 SHALL give sustained throughput of 1 transfer per 2 cycles; this is required, with no back-to-back accept in the cycle a handshake completes.
- REQ-021 SHALL, in BUSY with out_ready=0, remain in BUSY indefinitely; changes on req_valid are ignored.
- REQ-022 SHALL treat a requester that drops req_valid before being granted as no longer requesting; no request state is stored per requester.
- REQ-023 SHALL not let rr_ptr advance on cycles without a grant.
- REQ-024 SHALL derive req_ready only from state, req_valid and rr_ptr; there is no combinational path from out_ready to req_ready.

Reset
- REQ-025 SHALL, with reset=1 at a clock edge, force state=IDLE, rr_ptr=0, out_src=0, out_data=0 and xfer_count=0.
- REQ-026 SHALL hold out_valid=0 and req_ready=0 throughout any cycle in which reset=1, including mid-transfer in BUSY.
  - The pending payload is discarded.
  - xfer_count does not increment even if out_ready=1.
- REQ-027 SHALL grant first, after reset, to the lowest-index requester with req_valid set.

Verification
- REQ-028 Single request: req_valid=0b0100, req_data[2]=0xDEAD_BEEF_0000_0001, out_ready=1.
  - Expected: req_ready=0b0100 for 1 cycle.
  - Next cycle: out_valid=1, out_data=0xDEAD_BEEF_0000_0001, out_src=2.
  - Then out_valid=0 and xfer_count=1.
- REQ-029 Round-robin: req_valid=0b1111 held, out_ready=1.
  - Expected grant order 0,1,2,3,0,…; one grant every 2 cycles; xfer_count=8 after 16 cycles.
- REQ-030 Backpressure: grant requester 1, then hold out_ready=0 for 5 cycles while req_valid=0b1111.
  - Expected: out_valid=1 and out_data/out_src unchanged for all 5 cycles, req_ready=0.
  - After out_ready=1, the next grant goes to requester 2.
- REQ-031 Wrap: NUM_REQ=4, rr_ptr=3, req_valid=0b0011.
  - Expected: requester 0 granted, then rr_ptr=1.
- REQ-032 Reset mid-transfer: BUSY with out_src=3, assert reset for 1 cycle with out_ready=1.
  - Expected: out_valid=0, xfer_count=0, rr_ptr=0.
  - Next request 0b1010 grants requester 1.
